// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// mips_mem_pkg : memory access size encodings and store-buffer entry type
// Rev 1.0
// ============================================================================
package mips_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_BAD  = 2'b11;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [1:0]       size;
  } sb_entry_t;

  // The invalid encoding is treated as a word so overlap checks stay conservative
  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_overlap_chk.sv
`default_nettype none
// ============================================================================
// sb_overlap_chk : word-span overlap test of one load against one buffered store
// Rev 1.0
// ============================================================================
module sb_overlap_chk
  import mips_mem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] ld_addr,
  input  logic [1:0]    ld_size,
  input  logic          ent_valid,
  input  logic [AW-1:0] ent_addr,
  input  logic [1:0]    ent_size,
  output logic          hit
);

  logic [AW-1:0] w_ld_last;
  logic [AW-1:0] w_ent_last;
  logic [AW-3:0] w_ld_w0, w_ld_w1, w_ent_w0, w_ent_w1;
  logic          w_unused;

  assign w_ld_last  = ld_addr  + AW'(size_to_nbytes(ld_size)  - 3'd1);
  assign w_ent_last = ent_addr + AW'(size_to_nbytes(ent_size) - 3'd1);

  assign w_ld_w0  = ld_addr[AW-1:2];
  assign w_ld_w1  = w_ld_last[AW-1:2];
  assign w_ent_w0 = ent_addr[AW-1:2];
  assign w_ent_w1 = w_ent_last[AW-1:2];
  assign w_unused = ^{w_ld_last[1:0], w_ent_last[1:0]};

  assign hit = ent_valid &&
               ((w_ld_w0 == w_ent_w0) || (w_ld_w0 == w_ent_w1) ||
                (w_ld_w1 == w_ent_w0) || (w_ld_w1 == w_ent_w1));

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer : posted-write FIFO between MEM stage and data memory
// Rev 1.0
// ============================================================================
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    st_valid,
  input  logic [AW-1:0]           st_addr,
  input  logic [DW-1:0]           st_data,
  input  logic [1:0]              st_size,
  output logic                    st_ready,
  input  logic                    ld_valid,
  input  logic [AW-1:0]           ld_addr,
  input  logic [1:0]              ld_size,
  output logic                    ld_stall,
  output logic [DW-1:0]           ld_data,
  output logic                    mem_wr_en,
  output logic [AW-1:0]           mem_addr,
  output logic [1:0]              mem_data_size,
  output logic [DW-1:0]           mem_wr_data,
  input  logic [DW-1:0]           mem_rd_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int          PW     = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  sb_entry_t        r_ent [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;

  logic [DEPTH-1:0] w_hit;
  logic             w_enq;
  logic             w_ld_go;
  logic             w_drain;
  sb_entry_t        w_head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    sb_overlap_chk #(.AW(AW)) u_chk (
      .ld_addr   (ld_addr),
      .ld_size   (ld_size),
      .ent_valid (r_valid[i]),
      .ent_addr  (r_ent[i].addr),
      .ent_size  (r_ent[i].size),
      .hit       (w_hit[i])
    );
  end

  assign st_ready = (r_count != C_FULL);
  assign w_enq    = st_valid && st_ready && (st_size != MEM_BAD);
  assign ld_stall = ld_valid && (|w_hit);
  assign w_ld_go  = ld_valid && !ld_stall;
  // A stalled load yields the port, so the conflicting entries always drain
  assign w_drain  = !w_ld_go && (r_count != '0);
  assign w_head   = r_ent[r_head];
  assign ld_data  = mem_rd_data;
  assign empty    = (r_count == '0);
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_enq && !w_drain) begin
        r_count <= r_count + 1'b1;
      end else if (!w_enq && w_drain) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_ent[r_tail] <= '{addr: st_addr, data: st_data, size: st_size};
    end
  end

  always_comb begin
    mem_wr_en     = w_drain;
    mem_addr      = ld_addr;
    mem_data_size = ld_size;
    mem_wr_data   = '0;
    if (!rst_n) begin
      mem_addr      = '0;
      mem_data_size = MEM_WORD;
    end else if (w_drain) begin
      mem_addr      = w_head.addr;
      mem_data_size = w_head.size;
      mem_wr_data   = w_head.data;
    end
  end

endmodule
`default_nettype wire
